edu_dma_ctrl: RTL and testbench

DMA sequencer for the PCI edu device. It owns the edu DMA register set: source, destination, count and command. It moves 32-bit words between host memory and the device's 4 KiB internal buffer using the PCI core's single-dword master port. On completion it can signal the edu interrupt logic.

---
 rtl/edu_dma_ctrl.sv | 169 ++++++++++++++++
 tb/tb_edu_dma_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edu_dma_ctrl.sv
// DMA sequencer for the edu device: register set plus a word-at-a-time mover
// between host memory (single-dword master port) and the internal buffer.
//
// state     | meaning
// IDLE      | waiting for a start write to cmd
// RD_REQ    | host read request pending on the master port
// RD_WAIT   | waiting for read completion; completion writes the buffer
// BUF_FETCH | two cycles: buffer read issued, then read data captured
// WR_REQ    | host write request pending on the master port
// DONE      | transfer finished; optional interrupt pulse
module edu_dma_ctrl #(
  parameter logic [31:0] BUF_BASE  = 32'h0004_0000,
  parameter int          BUF_WORDS = 1024,
  localparam int         AW        = $clog2(BUF_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reg_wr,
  input  logic [7:0]    reg_addr,
  input  logic [31:0]   reg_wdata,
  output logic [31:0]   reg_rdata,
  output logic          mst_valid,
  input  logic          mst_ready,
  output logic          mst_write,
  output logic [31:0]   mst_addr,
  output logic [31:0]   mst_wdata,
  input  logic          mst_rdata_valid,
  input  logic [31:0]   mst_rdata,
  output logic          buf_en,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [31:0]   buf_wdata,
  input  logic [31:0]   buf_rdata,
  output logic          irq_raise,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, BUF_FETCH, WR_REQ, DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]   src_q, dst_q, cnt_q;
  logic          dir_q, irq_en_q;
  logic [31:0]   haddr_q, wdata_q;
  logic [AW-1:0] bidx_q;
  logic [29:0]   rem_q;
  logic          fetch_ph_q;

  logic          start, step, last, start_dir;
  logic [29:0]   word_cnt;
  logic [31:0]   start_host, start_other, start_offs;
  logic          unused_bits;

  assign busy       = (state != IDLE);
  assign start      = reg_wr && !busy && (reg_addr == 8'h98) && reg_wdata[0];
  assign start_dir  = reg_wdata[1];
  assign word_cnt   = cnt_q[31:2];
  assign start_host  = start_dir ? dst_q : src_q;
  assign start_other = start_dir ? src_q : dst_q;
  assign start_offs  = start_other - BUF_BASE;
  assign step = ((state == RD_WAIT) && mst_rdata_valid) || ((state == WR_REQ) && mst_ready);
  assign last = (rem_q == 30'd1);
  assign unused_bits = ^{cnt_q[1:0], start_offs[31:AW+2], start_offs[1:0]};

  assign mst_addr  = haddr_q;
  assign mst_wdata = wdata_q;
  assign buf_addr  = bidx_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mst_valid = 1'b0;
    mst_write = 1'b0;
    buf_en    = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    irq_raise = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt == '0) state_nx = DONE;
          else if (start_dir) state_nx = BUF_FETCH;
          else                state_nx = RD_REQ;
        end
      end
      RD_REQ: begin
        mst_valid = 1'b1;
        if (mst_ready) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (mst_rdata_valid) begin
          buf_en    = 1'b1;
          buf_we    = 1'b1;
          buf_wdata = mst_rdata;
          state_nx  = last ? DONE : RD_REQ;
        end
      end
      BUF_FETCH: begin
        buf_en = !fetch_ph_q;
        if (fetch_ph_q) state_nx = WR_REQ;
      end
      WR_REQ: begin
        mst_valid = 1'b1;
        mst_write = 1'b1;
        if (mst_ready) state_nx = last ? DONE : BUF_FETCH;
      end
      DONE: begin
        irq_raise = irq_en_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working copies; the programmed src/dst/cnt stay untouched by a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      haddr_q    <= '0;
      bidx_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      fetch_ph_q <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        case (reg_addr)
          8'h80: src_q <= reg_wdata;
          8'h88: dst_q <= reg_wdata;
          8'h90: cnt_q <= reg_wdata;
          8'h98: {irq_en_q, dir_q} <= reg_wdata[2:1];
          default: ;
        endcase
      end
      if (start) begin
        haddr_q <= {start_host[31:2], 2'b00};
        bidx_q  <= start_offs[AW+1:2];
        rem_q   <= word_cnt;
      end else if (step) begin
        haddr_q <= haddr_q + 32'd4;
        bidx_q  <= bidx_q + 1'b1;
        rem_q   <= rem_q - 30'd1;
      end
      fetch_ph_q <= (state == BUF_FETCH) ? !fetch_ph_q : 1'b0;
      if ((state == BUF_FETCH) && fetch_ph_q) wdata_q <= buf_rdata;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      8'h80: reg_rdata = src_q;
      8'h88: reg_rdata = dst_q;
      8'h90: reg_rdata = cnt_q;
      8'h98: reg_rdata = {29'b0, irq_en_q, dir_q, busy};
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_edu_dma_ctrl.sv
// Bench for edu_dma_ctrl: core and buffer models, scoreboard queues of expected
// master requests and buffer writes, one task per scenario.
module tb_edu_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        mst_valid, mst_write;
  logic        mst_ready = 1'b0;
  logic [31:0] mst_addr, mst_wdata;
  logic        mst_rdata_valid = 1'b0;
  logic [31:0] mst_rdata = '0;
  logic        buf_en, buf_we;
  logic [9:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata = '0;
  logic        irq_raise, busy;

  typedef struct { logic write; logic [31:0] addr; logic [31:0] data; } mst_t;
  typedef struct { logic [9:0] idx; logic [31:0] data; } bw_t;

  mst_t        exp_mst[$];
  bw_t         exp_buf[$];
  logic [31:0] host_rd_q[$];
  logic [31:0] mem [1024];

  int n_cmp = 0, n_fail = 0;
  int irq_cnt = 0, valid_cycles = 0, buf_cycles = 0;
  int rd_hs_cnt = 0, rd_hs_seen = 0;
  int ready_delay = 0, stall = 0;
  bit pend = 0;
  int pend_cnt = 0;
  bit pl_en = 0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  edu_dma_ctrl dut (
    .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .mst_valid(mst_valid), .mst_ready(mst_ready), .mst_write(mst_write),
    .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_rdata_valid(mst_rdata_valid), .mst_rdata(mst_rdata),
    .buf_en(buf_en), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .irq_raise(irq_raise), .busy(busy)
  );

  always #5 clk = ~clk;

  // Buffer RAM with one-cycle read latency; preload goes through this process.
  always @(posedge clk) begin
    if (buf_en && !buf_we) buf_rdata <= mem[buf_addr];
    if (buf_en && buf_we) mem[buf_addr] = buf_wdata;
    if (pl_en) mem[pl_idx] = pl_data;
  end

  // PCI core model: ready after ready_delay stall cycles, read data two cycles after accept.
  always @(posedge clk) begin
    #1;
    mst_rdata_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        mst_rdata_valid = 1'b1;
        mst_rdata = (host_rd_q.size() != 0) ? host_rd_q.pop_front() : 32'h0;
        pend = 0;
      end else pend_cnt--;
    end
    if (rd_hs_cnt != rd_hs_seen) begin
      rd_hs_seen = rd_hs_cnt;
      pend = 1;
      pend_cnt = 1;
    end
    if (mst_valid) begin
      if (stall < ready_delay) begin mst_ready = 1'b0; stall++; end
      else begin mst_ready = 1'b1; stall = 0; end
    end else begin
      mst_ready = 1'b0;
      stall = 0;
    end
  end

  // Scoreboard: every request cycle (stalled or not) must match the head of exp_mst.
  always @(negedge clk) begin
    if (mst_valid) begin
      valid_cycles++;
      n_cmp++;
      if (exp_mst.size() == 0) begin
        n_fail++;
        $display("FAIL mst_unexpected: got write=%b addr=%h, expected no request", mst_write, mst_addr);
      end else if (mst_addr !== exp_mst[0].addr || mst_write !== exp_mst[0].write ||
                   (mst_write && mst_wdata !== exp_mst[0].data)) begin
        n_fail++;
        $display("FAIL mst_req: got w=%b a=%h d=%h, expected w=%b a=%h d=%h", mst_write, mst_addr,
                 mst_wdata, exp_mst[0].write, exp_mst[0].addr, exp_mst[0].data);
      end
      if (mst_ready) begin
        if (exp_mst.size() != 0) void'(exp_mst.pop_front());
        if (!mst_write) rd_hs_cnt++;
      end
    end
    if (buf_en) buf_cycles++;
    if (buf_en && buf_we) begin
      n_cmp++;
      if (exp_buf.size() == 0) begin
        n_fail++;
        $display("FAIL buf_unexpected: got idx=%0d data=%h, expected no buffer write", buf_addr, buf_wdata);
      end else begin
        if (buf_addr !== exp_buf[0].idx || buf_wdata !== exp_buf[0].data) begin
          n_fail++;
          $display("FAIL buf_write: got idx=%0d data=%h, expected idx=%0d data=%h",
                   buf_addr, buf_wdata, exp_buf[0].idx, exp_buf[0].data);
        end
        void'(exp_buf.pop_front());
      end
    end
    if (irq_raise) irq_cnt++;
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got busy=%b, expected 0 within 400 cycles", nm, busy); end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [7:0] regs [4] = '{8'h80, 8'h88, 8'h90, 8'h98};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mst_valid, mst_write, mst_addr, mst_wdata, buf_en, buf_we, buf_addr, buf_wdata, irq_raise, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b addr=%h buf_en=%b busy=%b, expected all 0", mst_valid, mst_addr, buf_en, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(regs[i], v);
      n_cmp++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg_%h: got %h, expected 0", regs[i], v); end
    end
  endtask

  task automatic test_host_to_buf();
    logic [31:0] v;
    int irq0 = irq_cnt;
    wr(8'h80, 32'h1000_0000);
    wr(8'h88, 32'h0004_0000);
    wr(8'h90, 32'd16);
    for (int i = 0; i < 4; i++) begin
      exp_mst.push_back('{1'b0, 32'h1000_0000 + 32'(4 * i), 32'h0});
      host_rd_q.push_back(32'hA0 + 32'(i));
      exp_buf.push_back('{10'(i), 32'hA0 + 32'(i)});
    end
    rd(8'h84, v);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL h2b_unmapped: got %h, expected 0", v); end
    wr(8'h98, 32'h5);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL h2b_busy_start: got %b, expected 1", busy); end
    wait_idle("h2b");
    n_cmp++;
    if (irq_cnt - irq0 != 1) begin n_fail++; $display("FAIL h2b_irq: got %0d pulses, expected 1", irq_cnt - irq0); end
    rd(8'h98, v);
    n_cmp++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL h2b_cmd: got %h, expected 4", v); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL h2b_mem%0d: got %h, expected %h", i, mem[i], 32'hA0 + 32'(i)); end
    end
    n_cmp++;
    if (exp_mst.size() != 0 || exp_buf.size() != 0) begin
      n_fail++; $display("FAIL h2b_drain: got %0d/%0d left, expected 0/0", exp_mst.size(), exp_buf.size());
    end
  endtask

  task automatic test_buf_to_host();
    logic [31:0] v;
    int irq0 = irq_cnt;
    preload(10'd10, 32'hDEAD_0001);
    preload(10'd11, 32'hDEAD_0002);
    wr(8'h80, 32'h0004_0028);
    wr(8'h88, 32'h2000_0000);
    wr(8'h90, 32'd8);
    exp_mst.push_back('{1'b1, 32'h2000_0000, 32'hDEAD_0001});
    exp_mst.push_back('{1'b1, 32'h2000_0004, 32'hDEAD_0002});
    ready_delay = 3;
    wr(8'h98, 32'h3);
    wait_idle("b2h");
    ready_delay = 0;
    n_cmp++;
    if (irq_cnt != irq0) begin n_fail++; $display("FAIL b2h_irq: got %0d pulses, expected 0", irq_cnt - irq0); end
    rd(8'h98, v);
    n_cmp++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL b2h_cmd: got %h, expected 2", v); end
    n_cmp++;
    if (exp_mst.size() != 0) begin n_fail++; $display("FAIL b2h_drain: got %0d left, expected 0", exp_mst.size()); end
  endtask

  task automatic test_zero_count();
    int irq0 = irq_cnt, v0 = valid_cycles, b0 = buf_cycles, bc = 0;
    wr(8'h90, 32'h0);
    wr(8'h98, 32'h5);
    repeat (4) begin @(negedge clk); if (busy) bc++; end
    n_cmp++;
    if (bc != 1) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles, expected 1", bc); end
    n_cmp++;
    if (irq_cnt - irq0 != 1) begin n_fail++; $display("FAIL zero_irq: got %0d pulses, expected 1", irq_cnt - irq0); end
    n_cmp++;
    if (valid_cycles != v0 || buf_cycles != b0) begin
      n_fail++; $display("FAIL zero_activity: got %0d valid/%0d buf cycles, expected 0/0", valid_cycles - v0, buf_cycles - b0);
    end
  endtask

  task automatic test_wrap();
    wr(8'h80, 32'h3000_0000);
    wr(8'h88, 32'h0004_0FFC);
    wr(8'h90, 32'd8);
    exp_mst.push_back('{1'b0, 32'h3000_0000, 32'h0});
    exp_mst.push_back('{1'b0, 32'h3000_0004, 32'h0});
    host_rd_q.push_back(32'hB0);
    host_rd_q.push_back(32'hB1);
    exp_buf.push_back('{10'd1023, 32'hB0});
    exp_buf.push_back('{10'd0, 32'hB1});
    wr(8'h98, 32'h1);
    wait_idle("wrap");
    n_cmp++;
    if (exp_buf.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d left, expected 0", exp_buf.size()); end
  endtask

  task automatic test_busy_lockout();
    logic [31:0] v;
    wr(8'h80, 32'h5000_0000);
    wr(8'h88, 32'h0004_0100);
    wr(8'h90, 32'd12);
    for (int i = 0; i < 3; i++) begin
      exp_mst.push_back('{1'b0, 32'h5000_0000 + 32'(4 * i), 32'h0});
      host_rd_q.push_back(32'hC0 + 32'(i));
      exp_buf.push_back('{10'(64 + i), 32'hC0 + 32'(i)});
    end
    wr(8'h98, 32'h1);
    wr(8'h80, 32'hFFFF_FFFF);
    wr(8'h90, 32'h0);
    wr(8'h98, 32'h7);
    rd(8'h80, v);
    n_cmp++;
    if (v !== 32'h5000_0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL lock_src_busy: got src=%h busy=%b, expected 50000000 busy=1", v, busy);
    end
    wait_idle("lock");
    rd(8'h80, v);
    n_cmp++;
    if (v !== 32'h5000_0000) begin n_fail++; $display("FAIL lock_src: got %h, expected 50000000", v); end
    rd(8'h90, v);
    n_cmp++;
    if (v !== 32'd12) begin n_fail++; $display("FAIL lock_cnt: got %h, expected c", v); end
    rd(8'h98, v);
    n_cmp++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL lock_cmd: got %h, expected 0", v); end
    n_cmp++;
    if (exp_mst.size() != 0 || exp_buf.size() != 0) begin
      n_fail++; $display("FAIL lock_drain: got %0d/%0d left, expected 0/0", exp_mst.size(), exp_buf.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int n = 0;
    wr(8'h80, 32'h6000_0000);
    wr(8'h88, 32'h0004_0000);
    wr(8'h90, 32'd8);
    exp_mst.push_back('{1'b0, 32'h6000_0000, 32'h0});
    host_rd_q.push_back(32'h0BAD);
    wr(8'h98, 32'h5);
    while (exp_mst.size() != 0 && n < 100) begin @(posedge clk); n++; end
    n_cmp++;
    if (exp_mst.size() != 0) begin n_fail++; $display("FAIL rmid_handshake: got %0d pending, expected 0", exp_mst.size()); end
    #1;
    rst = 1'b1;
    wr(8'h98, 32'h5);
    @(negedge clk);
    n_cmp++;
    if ({mst_valid, mst_write, mst_addr, mst_wdata, buf_en, buf_we, buf_addr, buf_wdata, irq_raise, busy} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: got valid=%b addr=%h buf_en=%b busy=%b, expected all 0", mst_valid, mst_addr, buf_en, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd(8'h98, v);
    n_cmp++;
    if (v !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_start_in_rst: got cmd=%h busy=%b, expected 0 0", v, busy); end
    wr(8'h80, 32'h7000_0000);
    wr(8'h88, 32'h0004_0008);
    wr(8'h90, 32'd4);
    exp_mst.push_back('{1'b0, 32'h7000_0000, 32'h0});
    host_rd_q.push_back(32'hE7);
    exp_buf.push_back('{10'd2, 32'hE7});
    wr(8'h98, 32'h1);
    wait_idle("rmid_new");
    n_cmp++;
    if (mem[2] !== 32'hE7 || exp_buf.size() != 0) begin
      n_fail++; $display("FAIL rmid_new_xfer: got mem2=%h left=%0d, expected e7 0", mem[2], exp_buf.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_host_to_buf();
    test_buf_to_host();
    test_zero_count();
    test_wrap();
    test_busy_lockout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_mst.size() != 0 || exp_buf.size() != 0) begin
      n_fail++; $display("FAIL final_drain: got %0d/%0d left, expected 0/0", exp_mst.size(), exp_buf.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
